// File: rtl/iq_issue_select.sv
// Issue-queue select: picks the oldest ready entry by ROB age and feeds a
// single-entry issue stage with a valid/ready handshake toward the functional unit.
`timescale 1ns/1ps
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 6
`endif

module iq_issue_select #(
    parameter int ENTRIES   = 8,
    parameter int PAYLOAD_W = 256
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             flush,
    input  logic [ENTRIES-1:0]               entry_ready,
    input  logic [ENTRIES-1:0]               entry_robidx_flag,
    input  logic [ENTRIES*`ROB_SIZE_LOG-1:0] entry_robidx,
    input  logic [ENTRIES*PAYLOAD_W-1:0]     entry_payload,
    output logic [ENTRIES-1:0]               issuing,
    output logic                             iss_valid,
    input  logic                             iss_ready,
    output logic                             iss_robidx_flag,
    output logic [`ROB_SIZE_LOG-1:0]         iss_robidx,
    output logic [PAYLOAD_W-1:0]             iss_payload,
    output logic [15:0]                      perf_issue_cnt
);

    localparam int ROB_W = `ROB_SIZE_LOG;
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic                 r_iss_valid;
    logic                 r_iss_flag;
    logic [ROB_W-1:0]     r_iss_robidx;
    logic [PAYLOAD_W-1:0] r_iss_payload;
    logic [15:0]          r_perf_cnt;

    logic                 w_found;
    logic [IDX_W-1:0]     w_sel_idx;
    logic                 w_stage_free;
    logic                 w_fire;
    logic [ENTRIES-1:0]   w_issuing;

    // A is older than B: same wrap flag compares indices directly, differing
    // flags mean the larger index was allocated before the ROB wrapped.
    function automatic logic is_older(input logic fa, input logic [ROB_W-1:0] ia,
                                      input logic fb, input logic [ROB_W-1:0] ib);
        return (fa == fb) ? (ia < ib) : (ia > ib);
    endfunction

    // Ascending scan replaces the candidate only when strictly older, so age
    // ties resolve to the lowest entry number and the result is always one-hot.
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (entry_ready[i] &&
                (!w_found ||
                 is_older(entry_robidx_flag[i], entry_robidx[i*ROB_W +: ROB_W],
                          entry_robidx_flag[w_sel_idx],
                          entry_robidx[int'(w_sel_idx)*ROB_W +: ROB_W]))) begin
                w_found   = 1'b1;
                w_sel_idx = IDX_W'(i);
            end
        end
    end

    assign w_stage_free = ~r_iss_valid | iss_ready;
    assign w_fire       = reset_n & w_found & w_stage_free & ~flush;

    always_comb begin
        w_issuing = '0;
        if (w_fire) begin
            w_issuing[w_sel_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_iss_valid <= 1'b0;
            r_perf_cnt  <= 16'd0;
        end else begin
            if (flush) begin
                r_iss_valid <= 1'b0;
            end else if (w_fire) begin
                r_iss_valid <= 1'b1;
            end else if (iss_ready) begin
                r_iss_valid <= 1'b0;
            end
            if (r_iss_valid && iss_ready) begin
                r_perf_cnt <= r_perf_cnt + 16'd1;
            end
        end
    end

    // Data registers are only meaningful while valid, so they carry no reset.
    always_ff @(posedge clock) begin
        if (w_fire) begin
            r_iss_flag    <= entry_robidx_flag[w_sel_idx];
            r_iss_robidx  <= entry_robidx[int'(w_sel_idx)*ROB_W +: ROB_W];
            r_iss_payload <= entry_payload[int'(w_sel_idx)*PAYLOAD_W +: PAYLOAD_W];
        end
    end

    assign issuing         = w_issuing;
    assign iss_valid       = r_iss_valid;
    assign iss_robidx_flag = r_iss_flag;
    assign iss_robidx      = r_iss_robidx;
    assign iss_payload     = r_iss_payload;
    assign perf_issue_cnt  = r_perf_cnt;

endmodule
